// File: rtl/axi_lite_pkg.sv
// Shared constants, types and helpers for the AXI4-Lite register slave.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    // Ceiling log2, used to size the register index from the register count.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_lite_slave_decode.sv
// Address decoder: rebases a byte address onto the register bank, flags
// whether it lands inside the bank and extracts the word index.
module axi_lite_slave_decode
    import axi_lite_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                NUM_REGS  = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                IDX_W     = clog2(NUM_REGS)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  index,
    output logic [1:0]        resp
);

    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(NUM_REGS * 4);

    logic [ADDR_W-1:0] offset;

    // Unsigned subtract wraps addresses below the base to huge offsets, so a
    // single compare covers both sides of the window; byte lanes are ignored.
    always_comb begin
        offset = addr - BASE_ADDR;
        hit    = (offset < SPAN);
        index  = offset[IDX_W+1:2];
        resp   = hit ? RESP_OKAY : RESP_SLVERR;
    end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave exposing a bank of 32-bit read/write registers, with the
// register contents and per-register write strobes exported to fabric.
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int                            C_S_AXI_ADDR_WIDTH = 32,
    parameter int                            C_S_AXI_DATA_WIDTH = 32,
    parameter int                            C_NUM_REGS         = 16,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = 32'hC7000000
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] oRegs,
    output logic [C_NUM_REGS-1:0]                  oWrPulse
);

    localparam int ADDR_W = C_S_AXI_ADDR_WIDTH;
    localparam int DATA_W = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int IDX_W  = clog2(C_NUM_REGS);

    logic              ready_en;
    logic              aw_held;
    logic              w_held;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic              bvalid;
    logic [1:0]        bresp;
    logic [C_NUM_REGS-1:0] wr_pulse;
    logic [DATA_W-1:0] regs [C_NUM_REGS];

    logic              aw_ready;
    logic              w_ready;
    logic              aw_hs;
    logic              w_hs;
    logic              commit;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic              wr_hit;
    logic [IDX_W-1:0]  wr_idx;
    logic [1:0]        wr_resp;

    rd_state_t         rd_state;
    logic              ar_ready;
    logic              ar_hs;
    logic              rd_hit;
    logic [IDX_W-1:0]  rd_idx;
    logic [1:0]        rd_resp;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;

    logic              unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // Write side accepts address and data independently until a response is pending.
    assign aw_ready = ready_en & ~aw_held & ~bvalid;
    assign w_ready  = ready_en & ~w_held  & ~bvalid;
    assign aw_hs    = S_AXI_AWVALID & aw_ready;
    assign w_hs     = S_AXI_WVALID  & w_ready;
    assign commit   = (aw_hs | aw_held) & (w_hs | w_held);
    assign wr_addr  = aw_hs ? S_AXI_AWADDR : aw_addr_q;
    assign wr_data  = w_hs  ? S_AXI_WDATA  : w_data_q;
    assign wr_strb  = w_hs  ? S_AXI_WSTRB  : w_strb_q;

    assign ar_ready = ready_en & (rd_state == RD_IDLE);
    assign ar_hs    = S_AXI_ARVALID & ar_ready;

    axi_lite_slave_decode #(
        .ADDR_W    (ADDR_W),
        .NUM_REGS  (C_NUM_REGS),
        .BASE_ADDR (C_BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_aw_decode (
        .addr  (wr_addr),
        .hit   (wr_hit),
        .index (wr_idx),
        .resp  (wr_resp)
    );

    axi_lite_slave_decode #(
        .ADDR_W    (ADDR_W),
        .NUM_REGS  (C_NUM_REGS),
        .BASE_ADDR (C_BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_ar_decode (
        .addr  (S_AXI_ARADDR),
        .hit   (rd_hit),
        .index (rd_idx),
        .resp  (rd_resp)
    );

    // Holds the READY outputs low through reset and for the release edge itself.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Captures AW and W, commits the byte-masked write once both are present and runs the B handshake.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
            wr_pulse  <= '0;
        end else begin
            wr_pulse <= '0;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_resp;
                if (wr_hit) begin
                    wr_pulse[wr_idx] <= 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wr_strb[b]) begin
                            regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= S_AXI_WDATA;
                    w_strb_q <= S_AXI_WSTRB;
                end
                if (bvalid && S_AXI_BREADY) begin
                    bvalid <= 1'b0;
                end
            end
        end
    end

    // Read FSM: samples the register bank on the AR handshake (pre-write value on a same-edge commit) and holds R until accepted.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rd_state <= RD_IDLE;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
            rvalid   <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        rdata    <= rd_hit ? regs[rd_idx] : '0;
                        rresp    <= rd_resp;
                        rvalid   <= 1'b1;
                        rd_state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (S_AXI_RREADY) begin
                        rvalid   <= 1'b0;
                        rd_state <= RD_IDLE;
                    end
                end
                default: begin
                    rd_state <= RD_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_pack
        assign oRegs[g*DATA_W +: DATA_W] = regs[g];
    end

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = rresp;
    assign oWrPulse      = wr_pulse;

endmodule
